// File: rtl/audio_channel.sv
// -----------------------------------------------------------------------------
// audio_channel
//   One playback voice. Per-channel configuration is written through a
//   select/data register port. On every rising edge of the (synchronised)
//   I2S word clock the voice fetches the next 16-bit PCM sample, scales it by
//   the channel volume and presents it on o_SampleOut, placed in the left,
//   right or both word-clock halves.
//
// Ports
//   clk                  system clock
//   rst                  synchronous active-high reset (clears play state,
//                        FSM, word-clock synchroniser and output only)
//   w_ChannelData[23:0]  register write data, LSB-aligned
//   w_selectChannelData  register select
//   w_valid              write strobe, one write per clock while high
//   i_sample[15:0]       signed sample word from sample memory
//   i_ready              sample memory data valid
//   lrclk                asynchronous I2S word clock (low = left half)
//   o_SampleOut[15:0]    registered, signed scaled sample
//   o_nextSampleAddress  word address of the current sample
//
// Build option
//   CHANNEL_SATURATE_EN  when defined the scaled sample is clamped to the
//                        16-bit signed range; otherwise it wraps.
// -----------------------------------------------------------------------------
module audio_channel #(
  parameter int ADDR_WIDTH = 32,
  parameter int VOL_SHIFT  = 7
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [23:0]           w_ChannelData,
  input  logic [3:0]            w_selectChannelData,
  input  logic                  w_valid,
  input  logic [15:0]           i_sample,
  input  logic                  i_ready,
  input  logic                  lrclk,
  output logic [15:0]           o_SampleOut,
  output logic [ADDR_WIDTH-1:0] o_nextSampleAddress
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT    = 2'd1,
    ST_FETCH   = 2'd2,
    ST_ADVANCE = 2'd3
  } state_t;

  state_t      state_r;

  // Configuration registers (not touched by rst, except is_playing_r)
  logic [11:0] start_address_r;
  logic [23:0] sample_count_r;
  logic [23:0] loop_start_r;
  logic [23:0] loop_end_r;
  logic [23:0] position_r;
  logic [15:0] last_sample_r;
  logic [7:0]  volume_r;
  logic        is_looping_r;
  logic        is_playing_r;
  logic        is_mono_r;
  logic        is_left_r;

  // Word-clock synchroniser and edge detector
  logic        lr_sync1_r;
  logic        lr_sync2_r;
  logic        lr_prev_r;
  logic        frame_tick_s;

  logic [15:0]        out_r;
  logic [24:0]        next_pos_s;
  logic signed [24:0] product_s;
  logic signed [24:0] shifted_s;
  logic [15:0]        scaled_s;
  logic [15:0]        placed_s;

  assign frame_tick_s = lr_sync2_r & ~lr_prev_r;
  assign next_pos_s   = {1'b0, position_r} + 25'd1;

  assign o_nextSampleAddress = {{(ADDR_WIDTH-12){1'b0}}, start_address_r}
                             + {{(ADDR_WIDTH-24){1'b0}}, position_r};
  assign o_SampleOut = out_r;

  // Volume scaling: signed sample times unsigned volume, then fixed-point shift
  always_comb begin
    product_s = $signed(last_sample_r) * $signed({1'b0, volume_r});
    shifted_s = product_s >>> VOL_SHIFT;
    scaled_s  = shifted_s[15:0];
`ifdef CHANNEL_SATURATE_EN
    if (shifted_s > 25'sd32767) begin
      scaled_s = 16'h7FFF;
    end else if (shifted_s < -25'sd32768) begin
      scaled_s = 16'h8000;
    end else begin
      scaled_s = shifted_s[15:0];
    end
`endif
  end

  // Output placement: mono drives both halves, stereo only the channel's half
  always_comb begin
    placed_s = 16'h0000;
    if (is_mono_r) begin
      placed_s = scaled_s;
    end else if (is_left_r == ~lr_sync2_r) begin
      placed_s = scaled_s;
    end else begin
      placed_s = 16'h0000;
    end
  end

  // Fetch FSM, synchroniser, output register and register-port writes
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= ST_IDLE;
      is_playing_r <= 1'b0;
      lr_sync1_r   <= 1'b0;
      lr_sync2_r   <= 1'b0;
      lr_prev_r    <= 1'b0;
      out_r        <= 16'h0000;
    end else begin
      lr_sync1_r <= lrclk;
      lr_sync2_r <= lr_sync1_r;
      lr_prev_r  <= lr_sync2_r;
      out_r      <= placed_s;

      case (state_r)
        ST_IDLE: begin
          if (frame_tick_s && is_playing_r) begin
            state_r <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          // One cycle of memory read latency
          state_r <= ST_FETCH;
        end
        ST_FETCH: begin
          if (i_ready) begin
            last_sample_r <= i_sample;
            state_r       <= ST_ADVANCE;
          end
        end
        ST_ADVANCE: begin
          state_r <= ST_IDLE;
          if (is_looping_r && (next_pos_s == {1'b0, loop_end_r})) begin
            position_r <= loop_start_r;
          end else if (next_pos_s >= {1'b0, sample_count_r}) begin
            if (is_looping_r) begin
              position_r <= loop_start_r;
            end else begin
              position_r    <= 24'd0;
              is_playing_r  <= 1'b0;
              last_sample_r <= 16'h0000;
            end
          end else begin
            position_r <= next_pos_s[23:0];
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end

    // Register writes come last so they win over a same-cycle advance.
    // They are accepted during rst, but rst keeps is_playing cleared.
    if (w_valid) begin
      case (w_selectChannelData)
        4'd1:    start_address_r <= w_ChannelData[11:0];
        4'd2:    sample_count_r  <= w_ChannelData;
        4'd3:    loop_start_r    <= w_ChannelData;
        4'd4:    loop_end_r      <= w_ChannelData;
        4'd5:    position_r      <= w_ChannelData;
        4'd6:    last_sample_r   <= w_ChannelData[15:0];
        4'd7:    volume_r        <= w_ChannelData[7:0];
        4'd8:    is_looping_r    <= w_ChannelData[0];
        4'd9: begin
          if (!rst) begin
            is_playing_r <= w_ChannelData[0];
          end
        end
        4'd10:   is_mono_r       <= w_ChannelData[0];
        4'd11:   is_left_r       <= w_ChannelData[0];
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_audio_channel.sv
// -----------------------------------------------------------------------------
// tb_audio_channel
//   Directed bench for audio_channel. A 16-entry memory model answers reads at
//   the low four address bits; expected outputs are hand-computed constants.
// -----------------------------------------------------------------------------
module tb_audio_channel;

  logic        clk;
  logic        rst;
  logic [23:0] w_ChannelData;
  logic [3:0]  w_selectChannelData;
  logic        w_valid;
  logic [15:0] i_sample;
  logic        i_ready;
  logic        lrclk;
  logic [15:0] o_SampleOut;
  logic [31:0] o_nextSampleAddress;

  logic [15:0] mem [16];

  int n_cmp;
  int n_err;

`ifdef CHANNEL_SATURATE_EN
  localparam logic [15:0] EXP_POS_BIG = 16'h7FFF;
  localparam logic [15:0] EXP_NEG_BIG = 16'h8000;
`else
  localparam logic [15:0] EXP_POS_BIG = 16'hDF20;
  localparam logic [15:0] EXP_NEG_BIG = 16'h0100;
`endif

  audio_channel #(.ADDR_WIDTH(32), .VOL_SHIFT(7)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .w_ChannelData       (w_ChannelData),
    .w_selectChannelData (w_selectChannelData),
    .w_valid             (w_valid),
    .i_sample            (i_sample),
    .i_ready             (i_ready),
    .lrclk               (lrclk),
    .o_SampleOut         (o_SampleOut),
    .o_nextSampleAddress (o_nextSampleAddress)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Sample memory model
  always_comb i_sample = mem[o_nextSampleAddress[3:0]];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp = n_cmp + 1;
    if (got !== exp) begin
      n_err = n_err + 1;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic write_reg(input logic [3:0] sel, input logic [23:0] data);
    @(negedge clk);
    w_valid             = 1'b1;
    w_selectChannelData = sel;
    w_ChannelData       = data;
    @(negedge clk);
    w_valid             = 1'b0;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One word-clock period: rising edge, let the fetch finish, return low
  task automatic frame();
    @(negedge clk);
    lrclk = 1'b1;
    wait_cycles(10);
    lrclk = 1'b0;
    wait_cycles(5);
  endtask

  initial begin
    n_cmp               = 0;
    n_err               = 0;
    rst                 = 1'b1;
    w_valid             = 1'b0;
    w_selectChannelData = 4'd0;
    w_ChannelData       = 24'd0;
    i_ready             = 1'b1;
    lrclk               = 1'b0;
    for (int i = 0; i < 16; i++) mem[i] = 16'h0000;

    wait_cycles(3);
    check_val("reset_out", {16'h0000, o_SampleOut}, 32'h0000_0000);

    // Configuration written while rst is still asserted
    write_reg(4'd1,  24'd0);
    write_reg(4'd2,  24'd319488);
    write_reg(4'd3,  24'd0);
    write_reg(4'd4,  24'd191981);
    write_reg(4'd5,  24'd0);
    write_reg(4'd6,  24'd0);
    write_reg(4'd7,  24'd128);
    write_reg(4'd8,  24'd1);
    write_reg(4'd10, 24'd1);
    write_reg(4'd11, 24'd1);
    write_reg(4'd12, 24'hFFFFFF);
    @(negedge clk);
    rst = 1'b0;
    wait_cycles(2);
    check_val("cfg_out0", {16'h0000, o_SampleOut}, 32'h0000_0000);
    check_val("cfg_addr0", o_nextSampleAddress, 32'd0);

    // Address = start + position
    write_reg(4'd1, 24'h000010);
    check_val("addr_start", o_nextSampleAddress, 32'h0000_0010);
    write_reg(4'd5, 24'd3);
    check_val("addr_sum", o_nextSampleAddress, 32'h0000_0013);
    write_reg(4'd1, 24'd0);
    write_reg(4'd5, 24'd0);
    check_val("addr_back0", o_nextSampleAddress, 32'd0);

    // Not yet playing: a frame changes nothing
    mem[0] = 16'h1111;
    frame();
    check_val("idle_addr", o_nextSampleAddress, 32'd0);
    check_val("idle_out", {16'h0000, o_SampleOut}, 32'h0000_0000);

    // First frame at unity gain
    write_reg(4'd9, 24'd1);
    frame();
    check_val("first_out", {16'h0000, o_SampleOut}, 32'h0000_1111);
    check_val("first_addr", o_nextSampleAddress, 32'd1);

    // Volume scaling
    write_reg(4'd7, 24'd64);
    mem[1] = 16'h4000;
    frame();
    check_val("vol64_out", {16'h0000, o_SampleOut}, 32'h0000_2000);
    check_val("vol64_addr", o_nextSampleAddress, 32'd2);
    write_reg(4'd7, 24'd255);
    mem[2] = 16'h7000;
    frame();
    check_val("vol255_pos", {16'h0000, o_SampleOut}, {16'h0000, EXP_POS_BIG});
    mem[3] = 16'h8000;
    frame();
    check_val("vol255_neg", {16'h0000, o_SampleOut}, {16'h0000, EXP_NEG_BIG});
    check_val("vol255_addr", o_nextSampleAddress, 32'd4);

    // Memory stall holds the fetch in progress
    write_reg(4'd7, 24'd128);
    i_ready = 1'b0;
    mem[4]  = 16'h0F0F;
    frame();
    check_val("stall_out", {16'h0000, o_SampleOut}, 32'h0000_8000);
    check_val("stall_addr", o_nextSampleAddress, 32'd4);
    i_ready = 1'b1;
    wait_cycles(5);
    check_val("unstall_out", {16'h0000, o_SampleOut}, 32'h0000_0F0F);
    check_val("unstall_addr", o_nextSampleAddress, 32'd5);

    // Loop end wraps to loop start
    write_reg(4'd5, 24'd191980);
    check_val("loop_pre_addr", o_nextSampleAddress, 32'd191980);
    mem[12] = 16'h0ABC;
    frame();
    check_val("loop_out", {16'h0000, o_SampleOut}, 32'h0000_0ABC);
    check_val("loop_addr", o_nextSampleAddress, 32'd0);

    // Register write in the ADVANCE cycle wins over the advance
    mem[0] = 16'h0777;
    @(negedge clk);
    lrclk = 1'b1;
    wait_cycles(5);
    w_valid             = 1'b1;
    w_selectChannelData = 4'd5;
    w_ChannelData       = 24'd100;
    @(negedge clk);
    w_valid = 1'b0;
    wait_cycles(4);
    lrclk = 1'b0;
    wait_cycles(5);
    check_val("wr_wins_addr", o_nextSampleAddress, 32'd100);
    check_val("wr_wins_out", {16'h0000, o_SampleOut}, 32'h0000_0777);

    // Stereo placement
    write_reg(4'd10, 24'd0);
    write_reg(4'd5, 24'd0);
    mem[0] = 16'h1234;
    frame();
    check_val("st_left_lo", {16'h0000, o_SampleOut}, 32'h0000_1234);
    write_reg(4'd9, 24'd0);
    lrclk = 1'b1;
    wait_cycles(5);
    check_val("st_left_hi", {16'h0000, o_SampleOut}, 32'h0000_0000);
    lrclk = 1'b0;
    wait_cycles(5);
    check_val("st_left_lo2", {16'h0000, o_SampleOut}, 32'h0000_1234);
    write_reg(4'd11, 24'd0);
    wait_cycles(2);
    check_val("st_right_lo", {16'h0000, o_SampleOut}, 32'h0000_0000);
    lrclk = 1'b1;
    wait_cycles(5);
    check_val("st_right_hi", {16'h0000, o_SampleOut}, 32'h0000_1234);
    check_val("st_frozen_addr", o_nextSampleAddress, 32'd1);
    lrclk = 1'b0;
    wait_cycles(5);
    write_reg(4'd10, 24'd1);
    write_reg(4'd11, 24'd1);

    // End of sample without looping
    write_reg(4'd8, 24'd0);
    write_reg(4'd2, 24'd4);
    write_reg(4'd5, 24'd3);
    mem[3] = 16'h5555;
    write_reg(4'd9, 24'd1);
    frame();
    check_val("end_out", {16'h0000, o_SampleOut}, 32'h0000_0000);
    check_val("end_addr", o_nextSampleAddress, 32'd0);
    frame();
    check_val("end_stop_addr", o_nextSampleAddress, 32'd0);
    check_val("end_stop_out", {16'h0000, o_SampleOut}, 32'h0000_0000);

    // Reset in the WAIT state
    write_reg(4'd8, 24'd1);
    write_reg(4'd2, 24'd319488);
    write_reg(4'd5, 24'd0);
    write_reg(4'd7, 24'd64);
    mem[0] = 16'h4000;
    write_reg(4'd9, 24'd1);
    frame();
    check_val("pre_rst_out", {16'h0000, o_SampleOut}, 32'h0000_2000);
    check_val("pre_rst_addr", o_nextSampleAddress, 32'd1);
    @(negedge clk);
    lrclk = 1'b1;
    wait_cycles(3);
    rst = 1'b1;
    @(negedge clk);
    check_val("rst_mid_out", {16'h0000, o_SampleOut}, 32'h0000_0000);
    rst = 1'b0;
    wait_cycles(4);
    check_val("rst_vol_kept", {16'h0000, o_SampleOut}, 32'h0000_2000);
    check_val("rst_no_adv", o_nextSampleAddress, 32'd1);
    lrclk = 1'b0;
    wait_cycles(5);
    frame();
    check_val("rst_stopped", o_nextSampleAddress, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
